arb_mux_rr: RTL and testbench

- Parametrised successor to the plain N:1 M-bit selector.
- Merges N valid/ready input streams, each M bits wide, onto one registered output stream.
- Round-robin arbitration with a one-entry output register; sustains one beat per cycle.
- Used wherever several requesters share one downstream port, e.g. memory/bus request merging in the core.

---
 rtl/arb_mux_rr_pkg.sv | 17 +
 rtl/arb_mux_rr_arbiter.sv | 64 ++++++
 rtl/arb_mux_rr.sv | 78 +++++++
 tb/tb_arb_mux_rr.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the round-robin N:1 stream merger (arb_mux_rr).
// Holds default sizes, the index-width derivation and the rotating-index helper.
package arb_mux_rr_pkg;

    localparam int N_DEFAULT = 4;
    localparam int M_DEFAULT = 16;

    // Index width for n channels; a one-channel index still needs one bit.
    function automatic int sw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter_n: rotating-priority grant over N requests, holding the priority pointer.
// With ARB_MUX_LOCK_EN defined it also holds a lock onto one channel until its last beat.
module rr_arbiter_n
    import arb_mux_rr_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int SW = sw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic          last,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] ptr;
    logic [N-1:0]  eff_req;
    int            scan_idx;

`ifdef ARB_MUX_LOCK_EN
    logic          locked;
    logic [SW-1:0] lock_idx;
`endif

    // Scan from the highest offset down so the first requester at or after ptr wins.
    always_comb begin
        eff_req = req;
`ifdef ARB_MUX_LOCK_EN
        if (locked) eff_req = req & (N'(1) << lock_idx);
`endif
        grant     = '0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (eff_req[scan_idx]) grant_idx = SW'(scan_idx);
        end
        if (|eff_req) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
`ifdef ARB_MUX_LOCK_EN
            locked   <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (advance) begin
            if (last) begin
                ptr <= SW'(next_idx(int'(grant_idx), N));
`ifdef ARB_MUX_LOCK_EN
                locked <= 1'b0;
            end else begin
                locked   <= 1'b1;
                lock_idx <= grant_idx;
`endif
            end
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: merges N valid/ready streams of M bits onto one registered output stream.
// Optional packet locking (in_last/out_last) is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux_rr
    import arb_mux_rr_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    parameter  int M  = M_DEFAULT,
    localparam int SW = sw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_valid,
    input  logic [M*N-1:0] in_data,
    output logic [N-1:0]  in_ready,
    output logic          out_valid,
    output logic [M-1:0]  out_data,
    output logic [SW-1:0] out_sel,
    input  logic          out_ready
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic [N-1:0]  in_last,
    output logic          out_last
`endif
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid never waits for ready, and ready may follow out_ready combinationally.
    logic          load;
    logic          fire;
    logic          last;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [M-1:0]  grant_data;

    assign load       = ~out_valid | out_ready;
    assign fire       = load & ~rst & (|grant);
    assign in_ready   = fire ? grant : '0;
    assign grant_data = in_data[grant_idx*M +: M];

`ifdef ARB_MUX_LOCK_EN
    assign last = in_last[grant_idx];
`else
    assign last = 1'b1;
`endif

    rr_arbiter_n #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (fire),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef ARB_MUX_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (load) begin
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
`ifdef ARB_MUX_LOCK_EN
                out_last  <= last;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Self-checking bench for arb_mux_rr: N=4 and N=3 instances, expected-beat queues per instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_arb_mux_rr;

    localparam int M = 16;

`ifdef ARB_MUX_LOCK_EN
    localparam logic DFLT_LAST = 1'b1;
`else
    localparam logic DFLT_LAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic        out_last;

    logic [2:0]  in_valid3;
    logic [47:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [15:0] out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;
    logic        out_last3;

`ifdef ARB_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic [2:0]  in_last3;
`endif

    logic [18:0] exp_q[$];
    logic [18:0] exp3_q[$];
    logic [18:0] mon_exp;
    logic [18:0] mon_exp3;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    arb_mux_rr #(.N(4), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef ARB_MUX_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    arb_mux_rr #(.N(3), .M(M)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
`ifdef ARB_MUX_LOCK_EN
        ,
        .in_last   (in_last3),
        .out_last  (out_last3)
`endif
    );

`ifndef ARB_MUX_LOCK_EN
    assign out_last  = 1'b0;
    assign out_last3 = 1'b0;
`endif

    // Expected beat {last, sel, data}; channel i carries 16'hAAAA + i*16'h1111.
    function automatic logic [18:0] ent(input logic lst, input int ch);
        logic [15:0] d;
        d = 16'hAAAA + 16'(ch) * 16'h1111;
        return {lst, 2'(ch), d};
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL beat_unexpected got sel=%0d data=%h exp none", out_sel, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_last, out_sel, out_data} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL beat_n4 got last=%b sel=%0d data=%h exp last=%b sel=%0d data=%h",
                             out_last, out_sel, out_data, mon_exp[18], mon_exp[17:16], mon_exp[15:0]);
                end
            end
        end
        if (!rst && out_valid3 && out_ready3) begin
            n_checks++;
            if (exp3_q.size() == 0) begin
                n_errors++;
                $display("FAIL beat3_unexpected got sel=%0d data=%h exp none", out_sel3, out_data3);
            end else begin
                mon_exp3 = exp3_q.pop_front();
                if ({out_last3, out_sel3, out_data3} !== mon_exp3) begin
                    n_errors++;
                    $display("FAIL beat_n3 got last=%b sel=%0d data=%h exp last=%b sel=%0d data=%h",
                             out_last3, out_sel3, out_data3, mon_exp3[18], mon_exp3[17:16], mon_exp3[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp3_q.size() != 0); i++) tick();
        n_checks++;
        if (exp_q.size() != 0 || exp3_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout got left=%0d/%0d exp 0/0", exp_q.size(), exp3_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0) begin n_errors++; $display("FAIL rst_out_data got %h exp 0000", out_data); end
        if (out_sel !== 2'd0) begin n_errors++; $display("FAIL rst_out_sel got %0d exp 0", out_sel); end
        if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_in_ready got %b exp 0000", in_ready); end
        if (out_valid3 !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid3 got %b exp 0", out_valid3); end
        tick();
        rst      = 1'b0;
        in_valid = 4'h0;
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        foreach (seq[i]) exp_q.push_back(ent(DFLT_LAST, seq[i]));
        tick();
        in_valid = 4'hF;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL rr_first_grant got %b exp 0001", in_ready); end
        repeat (5) tick();
        in_valid = 4'h0;
        wait_drain();
    endtask

    task automatic test_stall();
        exp_q.push_back(ent(DFLT_LAST, 1));
        exp_q.push_back(ent(DFLT_LAST, 2));
        tick();
        in_valid  = 4'hF;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid c%0d got %b exp 1", i, out_valid); end
            if (out_data !== 16'hBBBB) begin n_errors++; $display("FAIL stall_data c%0d got %h exp BBBB", i, out_data); end
            if (out_sel !== 2'd1) begin n_errors++; $display("FAIL stall_sel c%0d got %0d exp 1", i, out_sel); end
            if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_in_ready c%0d got %b exp 0000", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b0100) begin n_errors++; $display("FAIL stall_refill got %b exp 0100", in_ready); end
        tick();
        in_valid = 4'h0;
        wait_drain();
    endtask

    task automatic test_sparse();
        logic [3:0] rdy_exp[4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        int seq[5] = '{1, 3, 1, 3, 1};
        foreach (seq[i]) exp_q.push_back(ent(DFLT_LAST, seq[i]));
        tick();
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== rdy_exp[i]) begin
                n_errors++;
                $display("FAIL sparse_in_ready c%0d got %b exp %b", i, in_ready, rdy_exp[i]);
            end
            tick();
        end
        in_valid = 4'h0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(DFLT_LAST, (i + 2) % 4));
        tick();
        in_valid = 4'hF;
        for (int c = 0; c < 400 && accepted < 8; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (|(in_valid & in_ready)) accepted++;
            tick();
        end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        n_checks++;
        if (accepted != 8) begin n_errors++; $display("FAIL b2b_accepts got %0d exp 8", accepted); end
        wait_drain();
    endtask

    task automatic test_non_pow2();
        int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
        foreach (seq[i]) exp3_q.push_back(ent(DFLT_LAST, seq[i]));
        tick();
        in_valid3 = 3'b111;
        repeat (7) tick();
        in_valid3 = 3'b000;
        wait_drain();
    endtask

`ifdef ARB_MUX_LOCK_EN
    task automatic test_lock();
        logic [3:0] rdy_exp[4]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        logic [3:0] last_drv[4] = '{4'b0000, 4'b0000, 4'b0100, 4'b1111};
        exp_q.push_back(ent(1'b0, 2));
        exp_q.push_back(ent(1'b0, 2));
        exp_q.push_back(ent(1'b1, 2));
        exp_q.push_back(ent(1'b1, 0));
        tick();
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_last = last_drv[i];
            @(negedge clk);
            n_checks++;
            if (in_ready !== rdy_exp[i]) begin
                n_errors++;
                $display("FAIL lock_in_ready c%0d got %b exp %b", i, in_ready, rdy_exp[i]);
            end
            tick();
        end
        in_valid = 4'h0;
        in_last  = 4'hF;
        wait_drain();
    endtask
`endif

    initial begin
        in_valid   = 4'h0;
        in_data    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        out_ready  = 1'b1;
        in_valid3  = 3'b000;
        in_data3   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        out_ready3 = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        in_last    = 4'hF;
        in_last3   = 3'b111;
`endif
        test_reset();
        test_round_robin();
        test_stall();
        test_sparse();
        test_back_to_back();
        test_non_pow2();
`ifdef ARB_MUX_LOCK_EN
        test_lock();
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
